// File: rtl/mul_div_seq_divider_if.sv
// Request/response bundle for the sequential divider: operation request,
// abort, and the busy/done/result status returned by the divider.
interface mul_div_seq_divider_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, kill, input busy, done, result);
  modport slave  (input start, op, a, b, kill, output busy, done, result);
endinterface

// File: rtl/mul_div_seq_divider.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH restoring steps on operand magnitudes
// FIX   | sign correction, result load
// DONE  | one-cycle completion pulse; accepts a back-to-back start
module mul_div_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_div_seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;

  logic [1:0]       op_q;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] quot, rem, div_q, result_q;
  logic [CW-1:0]    cnt;

  logic             accept, signed_op, sa, sb, div_zero, overflow, special;
  logic [WIDTH-1:0] mag_a, mag_b, special_res, fix_res, rem_nx;
  logic [WIDTH:0]   rem_sh, diff;
  logic             qbit;

  assign accept    = (state == IDLE || state == DONE) && bus.start && !bus.kill;
  assign signed_op = ~bus.op[0];
  assign sa        = signed_op & bus.a[WIDTH-1];
  assign sb        = signed_op & bus.b[WIDTH-1];
  assign mag_a     = sa ? -bus.a : bus.a;
  assign mag_b     = sb ? -bus.b : bus.b;
  assign div_zero  = (bus.b == '0);
  assign overflow  = signed_op && (bus.a == MIN_NEG) && (bus.b == '1);
  assign special   = div_zero || overflow;

  // Divide-by-zero and signed overflow finish without iterating
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = bus.op[1] ? bus.a : '1;
    else
      special_res = bus.op[1] ? '0 : bus.a;
  end

  assign rem_sh = {rem, quot[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, div_q};
  assign qbit   = ~diff[WIDTH];
  assign rem_nx = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

  always_comb begin
    fix_res = '0;
    if (op_q[1])
      fix_res = (!op_q[0] && sign_a) ? -rem : rem;
    else
      fix_res = (!op_q[0] && (sign_a ^ sign_b)) ? -quot : quot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_n = special ? DONE : CALC;
        else        state_n = IDLE;
      end
      CALC: begin
        if (bus.kill)      state_n = IDLE;
        else if (cnt == '0) state_n = FIX;
      end
      FIX: state_n = bus.kill ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q   <= bus.op;
            sign_a <= sa;
            sign_b <= sb;
            quot   <= mag_a;
            div_q  <= mag_b;
            rem    <= '0;
            cnt    <= CW'(WIDTH - 1);
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          if (!bus.kill) begin
            rem  <= rem_nx;
            quot <= {quot[WIDTH-2:0], qbit};
            cnt  <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!bus.kill) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == CALC) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
endmodule

// File: doc/mul_div_seq_divider.md
MUL_DIV_SEQ_DIVIDER -- requirements
Module: mul_div_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled on a rising edge of clk.
REQ-005 SHALL have port op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 SHALL have port a  input  WIDTH  dividend, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor, sampled with start.
REQ-008 SHALL have port kill  input  1  abort of an in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port result  output  WIDTH  quotient or remainder, valid while done=1.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 and kill=0, latch op, a, b and the signs, then go to CALC; otherwise DONE SHALL go to IDLE.
REQ-014 SHALL, in CALC, perform one restoring radix-2 step per cycle on the operand magnitudes (shift the remainder left, bring in the next dividend bit, subtract the divisor if no borrow, set the quotient bit) for exactly WIDTH cycles, then go to FIX.
REQ-015 SHALL, in FIX, negate the quotient if DIV and sign(a) XOR sign(b), negate the remainder if REM and sign(a), load result, then go to DONE.
REQ-016 SHALL treat the operands as unsigned for DIVU and REMU, taking no magnitude or sign correction.
REQ-017 SHALL give a latency of WIDTH+2 cycles for the normal path: start sampled at edge 0, busy=1 in cycles 1..WIDTH+1, and done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
REQ-018 SHALL, for divide by zero (b=0), skip CALC and FIX and go straight to DONE, with done=1 in cycle 1 and result = all-ones for DIV/DIVU and result = a for REM/REMU.
REQ-019 SHALL, for signed overflow (a = 100...0, b = all-ones, op DIV or REM), take the same one-cycle path, with result = a for DIV and result = 0 for REM.
REQ-020 SHALL drive done=1 only in DONE, for exactly one cycle per accepted operation.
REQ-021 SHALL drive busy=1 only in CALC and FIX.
REQ-022 SHALL hold result stable from DONE until the next completion.
REQ-023 SHALL ignore start while busy=1, with no effect on the in-flight operation.
REQ-024 SHALL accept a start asserted while done=1 (back-to-back), with the next done exactly WIDTH+2 cycles later.
REQ-025 SHALL, on kill=1 in CALC or FIX, go to IDLE on the next edge with no done pulse and result unchanged; kill SHALL take priority over start in the same cycle.
REQ-026 SHALL ignore kill in IDLE and DONE, except that kill=1 blocks acceptance of start in that cycle.

Reset
REQ-027 SHALL, while rst=1, immediately and asynchronously force state=IDLE, busy=0, done=0, result=0 and clear all internal registers, independent of clk.
REQ-028 SHALL, on rst asserted mid-operation, discard the operation and produce no done after rst deasserts.
REQ-029 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL verify DIV with a=-7 (0xFFFFFFF9), b=2: done in cycle 34, result=0xFFFFFFFD (-3); REM of the same operands gives 0xFFFFFFFF (-1).
REQ-031 SHALL verify DIVU with a=0xFFFFFFFF, b=0x10: result=0x0FFFFFFF; REMU of the same operands gives 0x0000000F.
REQ-032 SHALL verify divide by zero with a=0x12345678, b=0: done in cycle 1, DIV result=0xFFFFFFFF and REMU result=0x12345678.
REQ-033 SHALL verify DIV with a=0x80000000, b=0xFFFFFFFF: done in cycle 1, result=0x80000000; REM of the same operands gives 0x00000000.
REQ-034 SHALL verify that kill in cycle 10, or rst in cycle 10, gives busy=0 next cycle, no done, result unchanged (rst: 0), and that a following DIVU 100/7 gives result 14.
REQ-035 SHALL verify back-to-back operation: DIVU 100/7, then start held through done with REMU 100/7, gives done pulses 34 cycles apart with results 14 then 2; a start while busy changes nothing.
